// File: rtl/clock_display_scan_pkg.sv
// Shared constants for the 8-digit multiplexed clock display: segment codes,
// digit positions and the frame shadow record.
package clock_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [7:0] AN_OFF   = 8'hFF;

    localparam logic [2:0] POS_HRL  = 3'd7;
    localparam logic [2:0] POS_HRR  = 3'd6;
    localparam logic [2:0] POS_ML   = 3'd5;
    localparam logic [2:0] POS_MR   = 3'd4;
    localparam logic [2:0] POS_SL   = 3'd3;
    localparam logic [2:0] POS_SR   = 3'd2;
    localparam logic [2:0] POS_MILL = 3'd1;
    localparam logic [2:0] POS_MILM = 3'd0;

    // Separator dots sit after the hour, minute and second pairs.
    localparam logic [7:0] DP_SEP_MASK = (8'b1 << POS_HRR) | (8'b1 << POS_MR) | (8'b1 << POS_SR);

    typedef struct packed {
        logic [7:0][3:0] dig;   // dig[7] = hrL ... dig[0] = milM
        logic            fmt;
        logic            ampm;
    } shadow_t;

endpackage

// File: rtl/clock_display_scan_if.sv
// Time-in / display-out bundle between the clock core and the display scanner.
interface clock_display_scan_if;
    logic [3:0] hrL, hrR, mL, mR, sL, sR, milL, milM;
    logic       fmt;
    logic       ampm;
    logic [7:0] blink_mask;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output hrL, hrR, mL, mR, sL, sR, milL, milM, fmt, ampm, blink_mask,
        input  an, seg, dp
    );

    modport slave (
        input  hrL, hrR, mL, mR, sL, sR, milL, milM, fmt, ampm, blink_mask,
        output an, seg, dp
    );
endinterface

// File: rtl/clock_display_scan_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
    import clock_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/clock_display_scan.sv
// Multiplexed 8-digit display scanner with per-frame snapshot and guard blanking.
// Optional digit blinking is compiled in with `define BLINK_EN.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_display_scan_if.slave   bus
);
    localparam int unsigned DIV   = CLK_HZ / (SCAN_HZ * 8);
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_idx;
    logic             r_live;
    shadow_t          r_shadow;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic             w_tick;
    logic             w_blink_dark;
    logic [6:0]       w_seg_dec;
    logic [7:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic             w_dp_nxt;
    shadow_t          w_snap;

    assign w_tick = (r_pre == PRE_W'(DIV - 1));
    assign w_snap = '{dig:  {bus.hrL, bus.hrR, bus.mL, bus.mR, bus.sL, bus.sR, bus.milL, bus.milM},
                      fmt:  bus.fmt,
                      ampm: bus.ampm};

    // r_live keeps the display dark until the first frame has been captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre    <= '0;
            r_idx    <= '0;
            r_live   <= 1'b0;
            r_shadow <= '0;
        end else if (w_tick) begin
            r_pre  <= '0;
            r_idx  <= r_idx - 3'd1;
            r_live <= 1'b1;
            if (r_idx == POS_MILM)
                r_shadow <= w_snap;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

`ifdef BLINK_EN
    localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BLK_W-1:0] r_blk_cnt;
    logic             r_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blk_cnt <= BLK_W'(BLINK_HALF - 1);
            r_phase   <= 1'b0;
        end else if (r_blk_cnt == '0) begin
            r_blk_cnt <= BLK_W'(BLINK_HALF - 1);
            r_phase   <= ~r_phase;
        end else begin
            r_blk_cnt <= r_blk_cnt - BLK_W'(1);
        end
    end

    assign w_blink_dark = r_phase & bus.blink_mask[r_idx];
`else
    logic w_blink_unused;
    assign w_blink_unused = ^{bus.blink_mask, BLINK_HZ[0]};
    assign w_blink_dark   = 1'b0;
`endif

    bcd_to_seg u_dec (
        .i_bcd (r_shadow.dig[r_idx]),
        .o_seg (w_seg_dec)
    );

    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = 1'b1;
        if (r_live && !w_tick) begin
            w_an_nxt  = ~(8'b1 << r_idx);
            w_seg_nxt = w_seg_dec;
            w_dp_nxt  = ~(DP_SEP_MASK[r_idx] |
                          ((r_idx == POS_MILM) & r_shadow.fmt & r_shadow.ampm));
            if ((r_idx == POS_HRL) && r_shadow.fmt && (r_shadow.dig[POS_HRL] == 4'd0))
                w_an_nxt = AN_OFF;
            if (w_blink_dark) begin
                w_an_nxt = AN_OFF;
                w_dp_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with DIV=10 (80-cycle frame) and a 20-cycle blink window.
module tb_clock_display_scan;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

`ifdef BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    clock_display_scan_if bus ();

    clock_display_scan #(
        .CLK_HZ   (80),
        .SCAN_HZ  (1),
        .BLINK_HZ (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic set_digits(input logic [31:0] d);
        {bus.hrL, bus.hrR, bus.mL, bus.mR, bus.sL, bus.sR, bus.milL, bus.milM} = d;
    endtask

    task automatic test_reset;
        set_digits(32'h1234_5678);
        bus.fmt = 1'b0;
        bus.ampm = 1'b0;
        bus.blink_mask = 8'h00;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_hold an=%h seg=%h dp=%b expected an=ff seg=7f dp=1", bus.an, bus.seg, bus.dp);
            end
        end
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            wait_cyc(k);
            n_checks++;
            if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
                n_fail++;
                $display("FAIL pre_first_tick cyc=%0d an=%h seg=%h dp=%b expected all off", k, bus.an, bus.seg, bus.dp);
            end
        end
        wait_cyc(11);
        n_checks++;
        if (bus.an !== 8'h7F) begin
            n_fail++;
            $display("FAIL first_digit cyc=11 an=%h expected 7f", bus.an);
        end
    endtask

    task automatic test_digits;
        logic [7:0] an_exp  [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        logic [6:0] seg_exp [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
        logic       dp_exp  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            int g;
            g = 10 + 10 * i;
            if (g > cyc) begin
                wait_cyc(g);
                n_checks++;
                if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
                    n_fail++;
                    $display("FAIL guard slot=%0d an=%h seg=%h dp=%b expected all off", i, bus.an, bus.seg, bus.dp);
                end
            end
            wait_cyc(g + 1);
            n_checks++;
            if ({bus.an, bus.seg, bus.dp} !== {an_exp[i], seg_exp[i], dp_exp[i]}) begin
                n_fail++;
                $display("FAIL digit_first slot=%0d an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                         i, bus.an, bus.seg, bus.dp, an_exp[i], seg_exp[i], dp_exp[i]);
            end
            wait_cyc(g + 9);
            n_checks++;
            if ({bus.an, bus.seg, bus.dp} !== {an_exp[i], seg_exp[i], dp_exp[i]}) begin
                n_fail++;
                $display("FAIL digit_last slot=%0d an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                         i, bus.an, bus.seg, bus.dp, an_exp[i], seg_exp[i], dp_exp[i]);
            end
        end
    endtask

    task automatic test_mid_frame_change;
        wait_cyc(95);
        bus.hrR = 4'd9;
        wait_cyc(101);
        n_checks++;
        if ({bus.an, bus.seg} !== {8'hBF, 7'h24}) begin
            n_fail++;
            $display("FAIL snapshot_hold an=%h seg=%h expected an=bf seg=24", bus.an, bus.seg);
        end
        wait_cyc(171);
        n_checks++;
        if ({bus.an, bus.seg} !== {8'h7F, 7'h79}) begin
            n_fail++;
            $display("FAIL next_frame_hrL an=%h seg=%h expected an=7f seg=79", bus.an, bus.seg);
        end
        wait_cyc(181);
        n_checks++;
        if ({bus.an, bus.seg} !== {8'hBF, 7'h10}) begin
            n_fail++;
            $display("FAIL next_frame_hrR an=%h seg=%h expected an=bf seg=10", bus.an, bus.seg);
        end
    endtask

    task automatic test_fmt12;
        int an7_low = 0;
        wait_cyc(185);
        bus.hrL = 4'd0;
        bus.fmt = 1'b1;
        bus.ampm = 1'b1;
        for (int k = 251; k <= 329; k++) begin
            wait_cyc(k);
            if (k == 260) bus.fmt = 1'b0;
            if (bus.an[7] === 1'b0) an7_low++;
            if (k == 251) begin
                n_checks++;
                if (bus.an !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL lz_blank an=%h expected ff", bus.an);
                end
            end
            if (k == 321) begin
                n_checks++;
                if ({bus.an, bus.dp} !== {8'hFE, 1'b0}) begin
                    n_fail++;
                    $display("FAIL pm_dot an=%h dp=%b expected an=fe dp=0", bus.an, bus.dp);
                end
            end
        end
        n_checks++;
        if (an7_low !== 0) begin
            n_fail++;
            $display("FAIL lz_frame an7_low_cycles=%0d expected 0", an7_low);
        end
        wait_cyc(331);
        n_checks++;
        if ({bus.an, bus.seg} !== {8'h7F, 7'h40}) begin
            n_fail++;
            $display("FAIL fmt24_zero an=%h seg=%h expected an=7f seg=40", bus.an, bus.seg);
        end
        wait_cyc(401);
        n_checks++;
        if ({bus.an, bus.dp} !== {8'hFE, 1'b1}) begin
            n_fail++;
            $display("FAIL fmt24_no_pm an=%h dp=%b expected an=fe dp=1", bus.an, bus.dp);
        end
    endtask

    task automatic test_dash;
        bus.hrR = 4'hC;
        wait_cyc(421);
        n_checks++;
        if ({bus.an, bus.seg} !== {8'hBF, 7'h3F}) begin
            n_fail++;
            $display("FAIL dash an=%h seg=%h expected an=bf seg=3f", bus.an, bus.seg);
        end
    endtask

    task automatic test_blink;
        logic [7:0] an_p5;
        logic [7:0] an_p6;
        logic       dp_p6;
        an_p5 = BLINK_ON ? 8'hFF : 8'hDF;
        an_p6 = BLINK_ON ? 8'hFF : 8'hBF;
        dp_p6 = BLINK_ON ? 1'b1 : 1'b0;
        bus.blink_mask = 8'h30;
        for (int k = 431; k <= 439; k += 8) begin
            wait_cyc(k);
            n_checks++;
            if ({bus.an, bus.dp} !== {an_p5, 1'b1}) begin
                n_fail++;
                $display("FAIL blink_p5 cyc=%0d an=%h dp=%b expected an=%h dp=1", k, bus.an, bus.dp, an_p5);
            end
        end
        wait_cyc(441);
        n_checks++;
        if ({bus.an, bus.dp} !== {8'hEF, 1'b0}) begin
            n_fail++;
            $display("FAIL blink_p4_lit an=%h dp=%b expected an=ef dp=0", bus.an, bus.dp);
        end
        wait_cyc(451);
        n_checks++;
        if (bus.an !== 8'hF7) begin
            n_fail++;
            $display("FAIL blink_p3_unmasked an=%h expected f7", bus.an);
        end
        wait_cyc(455);
        bus.blink_mask = 8'h40;
        wait_cyc(491);
        n_checks++;
        if (bus.an !== 8'h7F) begin
            n_fail++;
            $display("FAIL blink_p7_unmasked an=%h expected 7f", bus.an);
        end
        for (int k = 501; k <= 509; k += 8) begin
            wait_cyc(k);
            n_checks++;
            if ({bus.an, bus.dp} !== {an_p6, dp_p6}) begin
                n_fail++;
                $display("FAIL blink_p6 cyc=%0d an=%h dp=%b expected an=%h dp=%b", k, bus.an, bus.dp, an_p6, dp_p6);
            end
        end
        wait_cyc(511);
        n_checks++;
        if (bus.an !== 8'hDF) begin
            n_fail++;
            $display("FAIL blink_live_mask an=%h expected df", bus.an);
        end
    endtask

    task automatic test_async_reset;
        wait_cyc(515);
        #2;
        n_checks++;
        if (bus.an !== 8'hDF) begin
            n_fail++;
            $display("FAIL pre_async an=%h expected df", bus.an);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL async_off an=%h seg=%h dp=%b expected all off", bus.an, bus.seg, bus.dp);
        end
        repeat (3) @(negedge clk);
        bus.blink_mask = 8'h00;
        set_digits(32'h1234_5678);
        bus.fmt = 1'b0;
        bus.ampm = 1'b0;
        rst = 1'b1;
        wait_cyc(10);
        n_checks++;
        if (bus.an !== 8'hFF) begin
            n_fail++;
            $display("FAIL restart_guard an=%h expected ff", bus.an);
        end
        wait_cyc(11);
        n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== {8'h7F, 7'h79, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_hrL an=%h seg=%h dp=%b expected an=7f seg=79 dp=1", bus.an, bus.seg, bus.dp);
        end
        wait_cyc(21);
        n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== {8'hBF, 7'h24, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_hrR an=%h seg=%h dp=%b expected an=bf seg=24 dp=0", bus.an, bus.seg, bus.dp);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_mid_frame_change();
        test_fmt12();
        test_dash();
        test_blink();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
